// File: rtl/bf_unit_pkg.sv
// Shared constants for the NTT butterfly unit: default modulus, Barrett constant and datapath widths.
// Width derivations assume 2^31 < Q < 2^32 with k = 32.
package bf_unit_pkg;

    localparam int Q_W  = 32;
    localparam int Q1_W = 33;
    localparam int R_W  = 34;

    localparam logic [Q_W-1:0]  BF_Q     = 32'd3221225473;
    localparam logic [Q1_W-1:0] BF_MU    = 33'd5726623059;
    localparam logic [R_W-1:0]  BF_TWO_Q = {1'b0, BF_Q, 1'b0};

endpackage

// File: rtl/bf_unit_cond_sub2.sv
// Final Barrett correction: folds a 34-bit remainder in 0..3Q-1 down to 0..Q-1; combinational.
// No flow control; purely a function of r.
module bf_unit_cond_sub2
    import bf_unit_pkg::*;
#(
    parameter logic [Q_W-1:0] Q     = BF_Q,
    parameter logic [R_W-1:0] TWO_Q = BF_TWO_Q
) (
    input  logic [R_W-1:0] r,
    output logic [Q_W-1:0] y
);

    localparam logic [R_W-1:0] Q_EXT = {2'b00, Q};

    always_comb begin
        y = r[Q_W-1:0];
        if (r >= TWO_Q) begin
            y = Q_W'(r - TWO_Q);
        end else if (r >= Q_EXT) begin
            y = Q_W'(r - Q_EXT);
        end
    end

endmodule

// File: rtl/bf_unit_barrett_reduce_64.sv
// Pipelined Barrett reducer: 64-bit product -> residue mod Q, 4 enabled cycles latency, 1 per enabled cycle.
// No backpressure; ce freezes every stage (data and valid) in place, reset clears everything immediately.
module bf_unit_barrett_reduce_64
    import bf_unit_pkg::*;
#(
    parameter logic [Q_W-1:0]  Q          = BF_Q,
    parameter logic [Q1_W-1:0] MU         = BF_MU,
    parameter int              DIN_WIDTH  = 64,
    parameter int              DOUT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  din_valid,
    input  logic [DIN_WIDTH-1:0]  din,
    output logic                  dout_valid,
    output logic [DOUT_WIDTH-1:0] dout
);

    localparam int PROD_W = 2 * Q1_W;

    logic [3:0]            vld_q,  vld_d;
    logic [R_W-1:0]        x1_q,   x1_d;
    logic [Q1_W-1:0]       q1_q,   q1_d;
    logic [R_W-1:0]        x2_q,   x2_d;
    logic [Q1_W-1:0]       q3_q,   q3_d;
    logic [R_W-1:0]        r_q,    r_d;
    logic [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic [Q_W-1:0]        sub_y;

    bf_unit_cond_sub2 #(
        .Q     (Q),
        .TWO_Q ({1'b0, Q, 1'b0})
    ) u_cond_sub2 (
        .r (r_q),
        .y (sub_y)
    );

    // Only x[33:0] survives past S1: the 34-bit wrap of x - q3*Q is exact.
    always_comb begin
        vld_d  = vld_q;
        x1_d   = x1_q;
        q1_d   = q1_q;
        x2_d   = x2_q;
        q3_d   = q3_q;
        r_d    = r_q;
        dout_d = dout_q;
        if (ce) begin
            vld_d  = {vld_q[2:0], din_valid};
            x1_d   = din[R_W-1:0];
            q1_d   = din[DIN_WIDTH-1:Q_W-1];
            x2_d   = x1_q;
            q3_d   = Q1_W'((PROD_W'(q1_q) * PROD_W'(MU)) >> Q1_W);
            r_d    = x2_q - R_W'(q3_q) * R_W'(Q);
            dout_d = sub_y;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            x1_q   <= '0;
            q1_q   <= '0;
            x2_q   <= '0;
            q3_q   <= '0;
            r_q    <= '0;
            dout_q <= '0;
        end else begin
            vld_q  <= vld_d;
            x1_q   <= x1_d;
            q1_q   <= q1_d;
            x2_q   <= x2_d;
            q3_q   <= q3_d;
            r_q    <= r_d;
            dout_q <= dout_d;
        end
    end

    assign dout_valid = vld_q[3];
    assign dout       = dout_q;

endmodule

// File: tb/tb_bf_unit_barrett_reduce_64.sv
// Directed bench for bf_unit_barrett_reduce_64: boundary vectors, streams, ce stalls, sparse valid, async reset.
module tb_bf_unit_barrett_reduce_64;

    localparam logic [63:0] QV = 64'd3221225473;
    localparam int N_STREAM = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        din_valid;
    logic [63:0] din;
    logic        dout_valid;
    logic [31:0] dout;

    int checks = 0;
    int errors = 0;

    logic [63:0] xs [N_STREAM];
    logic [63:0] exp_q [$];
    logic [31:0] prev_dout;
    logic        prev_vld;
    logic [5:0]  sparse_pat;
    logic [63:0] e;
    int          guard;

    bf_unit_barrett_reduce_64 dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .din_valid  (din_valid),
        .din        (din),
        .dout_valid (dout_valid),
        .dout       (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single directed vector: capture, then three more enabled edges.
    task automatic one(input string tag, input logic [63:0] x, input logic [63:0] exp);
        ce = 1'b1; din_valid = 1'b1; din = x;
        tick();
        din_valid = 1'b0; din = '0;
        tick(); tick();
        chk({tag, "_vld_early"}, {63'd0, dout_valid}, 64'd0);
        tick();
        chk({tag, "_vld"}, {63'd0, dout_valid}, 64'd1);
        chk(tag, {32'd0, dout}, exp);
    endtask

    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            checks++;
            assert ({32'd0, dout} < QV) else begin
                errors++;
                $error("FAIL range observed=%0d expected=below %0d", dout, QV);
            end
        end
    end

    initial begin
        reset = 1'b1; ce = 1'b0; din_valid = 1'b0; din = '0;
        #2;
        chk("reset_vld", {63'd0, dout_valid}, 64'd0);
        chk("reset_dout", {32'd0, dout}, 64'd0);
        tick();
        ce = 1'b1;
        tick();
        chk("reset_ce_vld", {63'd0, dout_valid}, 64'd0);
        #2 reset = 1'b0;
        tick();

        one("x_zero",     64'd0,                      64'd0);
        one("x_q",        QV,                         64'd0);
        one("x_q_m1",     QV - 64'd1,                 64'd3221225472);
        one("x_2p32",     64'h1_0000_0000,            64'd1073741823);
        one("x_qm1_sq",   (QV - 64'd1) * (QV - 64'd1), 64'd1);
        one("x_qsq_m1",   QV * QV - 64'd1,            64'd3221225472);
        one("x_one",      64'd1,                      64'd1);
        one("x_2q",       QV * 64'd2,                 64'd0);
        one("x_3q_m1",    QV * 64'd3 - 64'd1,         64'd3221225472);
        one("x_2p33",     64'h2_0000_0000,            64'd2147483646);
        one("x_2p63",     64'h8000_0000_0000_0000,    64'd2505397591);
        one("x_all_ones", 64'hFFFF_FFFF_FFFF_FFFF,    64'd1789569708);

        for (int i = 0; i < N_STREAM; i++) xs[i] = {$urandom, $urandom};
        xs[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        xs[1] = 64'd0;

        // Back-to-back stream
        ce = 1'b1;
        for (int i = 0; i < N_STREAM + 3; i++) begin
            if (i < N_STREAM) begin
                din_valid = 1'b1; din = xs[i];
                exp_q.push_back(xs[i] % QV);
            end else begin
                din_valid = 1'b0; din = '0;
            end
            tick();
            if (i >= 3) begin
                chk("stream_vld", {63'd0, dout_valid}, 64'd1);
                e = exp_q.pop_front();
                chk("stream_dout", {32'd0, dout}, e);
            end
        end
        din_valid = 1'b0;
        tick();
        chk("stream_tail_vld", {63'd0, dout_valid}, 64'd0);

        // Same data with ce toggling
        prev_dout = dout; prev_vld = dout_valid;
        begin
            int k;
            k = 0;
            guard = 0;
            while ((k < N_STREAM || exp_q.size() != 0) && guard < 20 * N_STREAM) begin
                guard++;
                ce = ($urandom_range(0, 99) >= 40);
                if (k < N_STREAM) begin
                    din_valid = 1'b1; din = xs[k];
                end else begin
                    din_valid = 1'b0; din = '0;
                end
                if (ce && k < N_STREAM) begin
                    exp_q.push_back(xs[k] % QV);
                    k++;
                end
                tick();
                if (!ce) begin
                    chk("stall_frozen_dout", {32'd0, dout}, {32'd0, prev_dout});
                    chk("stall_frozen_vld", {63'd0, dout_valid}, {63'd0, prev_vld});
                end else if (dout_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("stall_unexpected_out", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("stall_dout", {32'd0, dout}, e);
                    end
                end
                prev_dout = dout; prev_vld = dout_valid;
            end
            chk("stall_drained", 64'(exp_q.size()), 64'd0);
        end

        // Sparse valid pattern 1,0,0,1,1,0 (LSB first)
        ce = 1'b1;
        sparse_pat = 6'b011001;
        for (int i = 0; i < 12; i++) begin
            din_valid = (i < 6) ? sparse_pat[i] : 1'b0;
            din = 64'd12345 + 64'(i);
            tick();
            if (i >= 3 && i < 9) begin
                chk("sparse_vld", {63'd0, dout_valid}, {63'd0, sparse_pat[i-3]});
                if (sparse_pat[i-3]) chk("sparse_dout", {32'd0, dout}, 64'd12345 + 64'(i - 3));
            end else if (i < 3 || i >= 9) begin
                chk("sparse_idle_vld", {63'd0, dout_valid}, 64'd0);
            end
        end

        // Async reset with four items in flight
        for (int i = 0; i < 4; i++) begin
            din_valid = 1'b1; din = 64'd777 + 64'(i);
            tick();
        end
        din_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_vld", {63'd0, dout_valid}, 64'd0);
        chk("arst_dout", {32'd0, dout}, 64'd0);
        tick();
        #2 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("arst_no_stale", {63'd0, dout_valid}, 64'd0);
        end
        one("arst_new", 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567 % QV);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
